// File: rtl/text_buffer.sv
// rtl/text_buffer.sv - character-cell text memory with byte-stream cursor writer and registered cell read port
module text_buffer #(
    parameter int          COLS = 80,
    parameter int          ROWS = 22,
    parameter logic [11:0] FG0  = 12'h09E,
    parameter logic [11:0] BG0  = 12'h001,
    parameter logic [11:0] FG1  = 12'h3C1,
    parameter logic [11:0] BG1  = 12'h001
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  CX,
    input  logic [7:0]  CY,
    output logic [6:0]  character,
    output logic [11:0] foreground,
    output logic [11:0] background,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y
);

    localparam int          CELLS     = COLS * ROWS;
    localparam logic [10:0] LAST_CELL = 11'(CELLS - 1);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    // Cell layout is {attr, char[6:0]}; a blank cell is a space with attribute 0.
    localparam logic [7:0]  BLANK     = 8'h20;

    typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_ROW} state_t;

    state_t      state;
    logic [7:0]  mem [CELLS];
    logic [10:0] clr_addr;
    logic [10:0] clr_last;
    logic        cur_attr;

    logic        accept;
    logic        printable;
    logic        do_newline;
    logic [10:0] cur_addr;
    logic [4:0]  nl_row;
    logic [10:0] nl_base;
    logic        mem_we;
    logic [10:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        in_grid;
    logic [10:0] rd_addr;
    logic [7:0]  rd_cell;

    assign accept     = wr_valid & wr_ready;
    assign printable  = (wr_data >= 8'h20) && (wr_data <= 8'h7E);
    assign do_newline = accept && ((printable && cursor_x == LAST_COL) || wr_data == 8'h0A);
    assign cur_addr   = 11'(cursor_y) * 11'(COLS) + 11'(cursor_x);
    assign nl_row     = (cursor_y == LAST_ROW) ? 5'd0 : cursor_y + 5'd1;
    assign nl_base    = 11'(nl_row) * 11'(COLS);

    // Single write port shared by the character writer and the clear sweeps.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_addr;
        mem_wdata = BLANK;
        if (state != IDLE) begin
            mem_we = reset_n;
        end else if (accept && printable) begin
            mem_we    = 1'b1;
            mem_waddr = cur_addr;
            mem_wdata = {cur_attr, wr_data[6:0]};
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign in_grid = (CX < 8'(COLS)) && (CY < 8'(ROWS));
    assign rd_addr = in_grid ? 11'(CY) * 11'(COLS) + 11'(CX) : 11'd0;
    assign rd_cell = mem[rd_addr];

    // Same-cycle write to the scanned cell is not bypassed: the old contents are returned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            character  <= 7'd0;
            foreground <= FG0;
            background <= BG0;
        end else if (in_grid) begin
            character  <= rd_cell[6:0];
            foreground <= rd_cell[7] ? FG1 : FG0;
            background <= rd_cell[7] ? BG1 : BG0;
        end else begin
            character  <= 7'd0;
            foreground <= FG0;
            background <= BG0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLR_ALL;
            wr_ready <= 1'b0;
            clr_addr <= 11'd0;
            clr_last <= LAST_CELL;
            cursor_x <= 7'd0;
            cursor_y <= 5'd0;
            cur_attr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_newline) begin
                        cursor_x <= 7'd0;
                        cursor_y <= nl_row;
                        state    <= CLR_ROW;
                        wr_ready <= 1'b0;
                        clr_addr <= nl_base;
                        clr_last <= nl_base + 11'(COLS - 1);
                    end else if (accept) begin
                        if (printable) begin
                            cursor_x <= cursor_x + 7'd1;
                        end else begin
                            case (wr_data)
                                8'h0D: cursor_x <= 7'd0;
                                8'h08: if (cursor_x != 7'd0) cursor_x <= cursor_x - 7'd1;
                                8'h0C: begin
                                    cursor_x <= 7'd0;
                                    cursor_y <= 5'd0;
                                    state    <= CLR_ALL;
                                    wr_ready <= 1'b0;
                                    clr_addr <= 11'd0;
                                    clr_last <= LAST_CELL;
                                end
                                8'h0E: cur_attr <= 1'b0;
                                8'h0F: cur_attr <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                end
                CLR_ALL, CLR_ROW: begin
                    if (clr_addr == clr_last) begin
                        state    <= IDLE;
                        wr_ready <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 11'd1;
                    end
                end
                default: begin
                    state    <= CLR_ALL;
                    wr_ready <= 1'b0;
                    clr_addr <= 11'd0;
                    clr_last <= LAST_CELL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_buffer.sv
// tb/tb_text_buffer.sv - scoreboard bench for text_buffer
module tb_text_buffer;

    localparam int          COLS = 80;
    localparam int          ROWS = 22;
    localparam logic [11:0] FG0  = 12'h09E;
    localparam logic [11:0] BG0  = 12'h001;
    localparam logic [11:0] FG1  = 12'h3C1;
    localparam logic [11:0] BG1  = 12'h001;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic [7:0]  wr_data  = 8'h00;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  CX       = 8'd0;
    logic [7:0]  CY       = 8'd0;
    logic [6:0]  character;
    logic [11:0] foreground;
    logic [11:0] background;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;

    text_buffer #(
        .COLS(COLS), .ROWS(ROWS), .FG0(FG0), .BG0(BG0), .FG1(FG1), .BG1(BG1)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .CX(CX), .CY(CY),
        .character(character), .foreground(foreground), .background(background),
        .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0]  ch;
        logic [11:0] fg;
        logic [11:0] bg;
        int          x;
        int          y;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int      checks = 0;
    int      errors = 0;
    logic    rd_en  = 1'b0;
    logic    rd_vld = 1'b0;

    always @(posedge clock) rd_vld <= rd_en;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("rd_char(%0d,%0d)", e.x, e.y), int'(character), int'(e.ch));
                chk($sformatf("rd_fg(%0d,%0d)", e.x, e.y), int'(foreground), int'(e.fg));
                chk($sformatf("rd_bg(%0d,%0d)", e.x, e.y), int'(background), int'(e.bg));
            end
        end
    end

    task automatic rd_issue(input int x, input int y, input logic [6:0] ch, input logic attr);
        rd_exp_t e;
        CX    = 8'(x);
        CY    = 8'(y);
        rd_en = 1'b1;
        e.ch = ch;
        e.fg = attr ? FG1 : FG0;
        e.bg = attr ? BG1 : BG0;
        e.x  = x;
        e.y  = y;
        exp_q.push_back(e);
    endtask

    task automatic read_cell(input int x, input int y, input logic [6:0] ch, input logic attr);
        rd_issue(x, y, ch, attr);
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!wr_ready && n < 4000) begin
            @(negedge clock);
            n++;
        end
        if (!wr_ready) begin
            chk("send_stall", 0, 1);
            return;
        end
        wr_data  = b;
        wr_valid = 1'b1;
        @(negedge clock);
        wr_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int exp);
        int n = 0;
        while (!wr_ready && n < exp + 200) begin
            n++;
            @(negedge clock);
        end
        chk(name, n, exp);
    endtask

    task automatic chk_cursor(input string name, input int x, input int y);
        chk({name, "_x"}, int'(cursor_x), x);
        chk({name, "_y"}, int'(cursor_y), y);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_ready", int'(wr_ready), 0);
        chk_cursor("reset_cursor", 0, 0);
        chk("reset_char", int'(character), 0);
        chk("reset_fg", int'(foreground), int'(FG0));
        chk("reset_bg", int'(background), int'(BG0));
        reset_n = 1'b1;
        wait_ready("init_clear_len", COLS * ROWS);

        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                read_cell(x, y, 7'h20, 1'b0);

        send_byte(8'h41);
        chk_cursor("after_A", 1, 0);
        read_cell(0, 0, 7'h41, 1'b0);

        send_byte(8'h0D);
        send_byte(8'h0F);
        send_byte(8'h42);
        send_byte(8'h0E);
        send_byte(8'h43);
        chk_cursor("after_BC", 2, 0);
        read_cell(0, 0, 7'h42, 1'b1);
        read_cell(1, 0, 7'h43, 1'b0);

        // write and read the same cell in the same cycle
        wr_data  = 8'h44;
        wr_valid = 1'b1;
        rd_issue(2, 0, 7'h20, 1'b0);
        @(negedge clock);
        wr_valid = 1'b0;
        rd_issue(2, 0, 7'h44, 1'b0);
        @(negedge clock);
        rd_en = 1'b0;
        chk_cursor("after_D", 3, 0);

        send_byte(8'h08);
        chk_cursor("bs_mid", 2, 0);
        send_byte(8'h0D);
        chk_cursor("cr", 0, 0);
        send_byte(8'h08);
        chk_cursor("bs_zero", 0, 0);
        send_byte(8'h01);
        chk_cursor("ignored", 0, 0);
        chk("ignored_ready", int'(wr_ready), 1);

        read_cell(80, 0, 7'h00, 1'b0);
        read_cell(0, 22, 7'h00, 1'b0);
        read_cell(255, 255, 7'h00, 1'b0);
        read_cell(79, 21, 7'h20, 1'b0);

        for (int i = 0; i < COLS; i++) begin
            send_byte(8'(8'h21 + i));
            if (i < COLS - 1) chk("fill_ready", int'(wr_ready), 1);
            if (i == COLS - 2) chk_cursor("fill_last_col", 79, 0);
        end
        chk_cursor("fill_wrap", 0, 1);
        wait_ready("wrap_clear_len", COLS);
        for (int x = 0; x < COLS; x++) read_cell(x, 0, 7'(8'h21 + x), 1'b0);
        for (int x = 0; x < COLS; x++) read_cell(x, 1, 7'h20, 1'b0);

        send_byte(8'h0F);
        send_byte(8'h58);
        send_byte(8'h59);
        send_byte(8'h0E);
        chk_cursor("after_XY", 2, 1);
        send_byte(8'h0A);
        // hold a byte while the row clear runs
        wr_data  = 8'h51;
        wr_valid = 1'b1;
        chk_cursor("lf", 0, 2);
        wait_ready("lf_clear_len", COLS);
        chk_cursor("held", 0, 2);
        @(negedge clock);
        wr_valid = 1'b0;
        chk_cursor("held_accept", 1, 2);
        read_cell(0, 1, 7'h58, 1'b1);
        read_cell(1, 1, 7'h59, 1'b1);
        read_cell(0, 2, 7'h51, 1'b0);

        for (int k = 0; k < 19; k++) begin
            send_byte(8'h0A);
            wait_ready("lf_loop_len", COLS);
        end
        chk_cursor("row21", 0, 21);
        send_byte(8'h0A);
        chk_cursor("row_wrap", 0, 0);
        wait_ready("row_wrap_len", COLS);
        for (int x = 0; x < COLS; x++) read_cell(x, 0, 7'h20, 1'b0);
        read_cell(0, 1, 7'h58, 1'b1);

        send_byte(8'h41);
        send_byte(8'h0C);
        chk_cursor("ff", 0, 0);
        wait_ready("ff_len", COLS * ROWS);
        read_cell(0, 0, 7'h20, 1'b0);

        send_byte(8'h5A);
        chk_cursor("after_Z", 1, 0);
        CX = 8'd0;
        CY = 8'd0;
        send_byte(8'h0C);
        chk_cursor("ff2", 0, 0);
        repeat (499) @(negedge clock);
        chk("ff_mid_ready", int'(wr_ready), 0);
        chk("ff_mid_char", int'(character), 8'h20);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_mid_ready", int'(wr_ready), 0);
        chk("rst_mid_char", int'(character), 0);
        chk("rst_mid_fg", int'(foreground), int'(FG0));
        chk_cursor("rst_mid_cursor", 0, 0);
        reset_n = 1'b1;
        wait_ready("rst_restart_len", COLS * ROWS);
        chk_cursor("rst_restart_cursor", 0, 0);
        read_cell(0, 0, 7'h20, 1'b0);
        read_cell(5, 21, 7'h20, 1'b0);

        repeat (3) @(negedge clock);
        chk("queue_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
